password_setter: RTL and testbench

Password-change front end for the lock datapath: owns the stored 6-bit password and drives the `pw_6` bus that the password checker compares against. While the checker reports the unlocked state, a user enters a new password on the switches, confirms it, re-enters it, and confirms again. On a match the stored password is updated; otherwise the attempt is counted and rejected. It sits between the switch/button inputs and the checker, on the same `Clk` domain.

---
 rtl/password_setter.sv | 170 +++++++++++++++++
 tb/tb_password_setter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/password_setter.sv
// Password-change front end: holds the stored password and runs the enter/re-enter/confirm session.
// Optional inactivity abort is compiled in with `define PWSET_TIMEOUT_EN.
module password_setter #(
    parameter logic [5:0] DEFAULT_PW = 6'b000000,
    parameter int         MAX_TRIES  = 3,
    parameter int         TIMEOUT    = 1000
) (
    input  logic       Clk,
    input  logic       Res,
    input  logic [7:0] in_8,
    input  logic       Unlocked,
    input  logic       Set,
    input  logic       Confirm,
    input  logic       Cancel,
    output logic [5:0] pw_6,
    output logic [1:0] phase,
    output logic [1:0] err_cnt,
    output logic       done,
    output logic       fail,
    output logic       invalid
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ENTER1 = 2'b01,
        ENTER2 = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] pw_q, pw_d;
    logic [5:0] first_q, first_d;
    logic [1:0] err_q, err_d;
    logic       done_q, done_d;
    logic       fail_q, fail_d;
    logic       inv_q, inv_d;
    logic       set_prev_q, cnf_prev_q, cnc_prev_q;

    logic set_edge, cnf_edge, cnc_edge, any_edge;
    logic entry_ok, tmo_hit, abort;

    assign set_edge = Set & ~set_prev_q;
    assign cnf_edge = Confirm & ~cnf_prev_q;
    assign cnc_edge = Cancel & ~cnc_prev_q;
    assign any_edge = set_edge | cnf_edge | cnc_edge;
    assign entry_ok = (in_8[7:6] == 2'b00);

`ifdef PWSET_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

    logic [19:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LAST);

    // Counter runs only inside a session and restarts on every button edge.
    always_comb begin
        tmo_d = tmo_q + 20'd1;
        if (state_q == IDLE || state_d == IDLE || any_edge) begin
            tmo_d = 20'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Res) begin
            tmo_q <= 20'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_cfg;

    assign tmo_hit        = 1'b0;
    assign unused_tmo_cfg = (TIMEOUT > 0) | any_edge;
`endif

    // Session aborts rank Unlocked-low, then timeout, then Cancel, all above Confirm.
    assign abort = (state_q != IDLE) && (!Unlocked || tmo_hit || cnc_edge);

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        first_d = first_q;
        err_d   = err_q;
        done_d  = 1'b0;
        fail_d  = 1'b0;
        inv_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            err_d   = 2'd0;
            fail_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (set_edge && Unlocked) begin
                        state_d = ENTER1;
                        err_d   = 2'd0;
                    end
                end
                ENTER1: begin
                    if (cnf_edge) begin
                        if (!entry_ok) begin
                            inv_d = 1'b1;
                        end else begin
                            first_d = in_8[5:0];
                            state_d = ENTER2;
                        end
                    end
                end
                ENTER2: begin
                    if (cnf_edge) begin
                        if (!entry_ok) begin
                            inv_d = 1'b1;
                        end else if (in_8[5:0] == first_q) begin
                            pw_d    = in_8[5:0];
                            done_d  = 1'b1;
                            err_d   = 2'd0;
                            state_d = IDLE;
                        end else if (int'(err_q) + 1 == MAX_TRIES) begin
                            fail_d  = 1'b1;
                            err_d   = 2'd0;
                            state_d = IDLE;
                        end else begin
                            err_d   = err_q + 2'd1;
                            state_d = ENTER1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Previous-level registers reset high so a button held through reset is not an edge.
    always_ff @(posedge Clk) begin
        if (Res) begin
            state_q    <= IDLE;
            pw_q       <= DEFAULT_PW;
            first_q    <= 6'd0;
            err_q      <= 2'd0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            inv_q      <= 1'b0;
            set_prev_q <= 1'b1;
            cnf_prev_q <= 1'b1;
            cnc_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            first_q    <= first_d;
            err_q      <= err_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            inv_q      <= inv_d;
            set_prev_q <= Set;
            cnf_prev_q <= Confirm;
            cnc_prev_q <= Cancel;
        end
    end

    assign pw_6    = pw_q;
    assign phase   = state_q;
    assign err_cnt = err_q;
    assign done    = done_q;
    assign fail    = fail_q;
    assign invalid = inv_q;

endmodule

// File: tb/tb_password_setter.sv
// Directed bench for password_setter: per-cycle vector table plus hand-written hold/reset/timeout sequences.
module tb_password_setter;

    logic       Clk = 1'b0;
    logic       Res, Unlocked, Set, Confirm, Cancel;
    logic [7:0] in_8;
    logic [5:0] pw_6;
    logic [1:0] phase, err_cnt;
    logic       done, fail, invalid;

    int total = 0;
    int bad   = 0;

`ifdef PWSET_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
    localparam int HOLD   = 6;
`else
    localparam bit TMO_ON = 1'b0;
    localparam int HOLD   = 20;
`endif

    password_setter #(
        .DEFAULT_PW(6'h00),
        .MAX_TRIES (3),
        .TIMEOUT   (8)
    ) dut (
        .Clk     (Clk),
        .Res     (Res),
        .in_8    (in_8),
        .Unlocked(Unlocked),
        .Set     (Set),
        .Confirm (Confirm),
        .Cancel  (Cancel),
        .pw_6    (pw_6),
        .phase   (phase),
        .err_cnt (err_cnt),
        .done    (done),
        .fail    (fail),
        .invalid (invalid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       res, unl, set, cnf, cnc;
        logic [7:0] din;
        logic [5:0] pw;
        logic [1:0] ph, err;
        logic       dn, fl, iv;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic res, unl, set, cnf, cnc, input logic [7:0] din,
                       input logic [5:0] pw, input logic [1:0] ph, err, input logic dn, fl, iv);
        vec_t v;
        v.res = res; v.unl = unl; v.set = set; v.cnf = cnf; v.cnc = cnc; v.din = din;
        v.pw = pw; v.ph = ph; v.err = err; v.dn = dn; v.fl = fl; v.iv = iv;
        tbl.push_back(v);
    endtask

    // Apply one cycle of inputs, clock, then compare all outputs 1 time unit after the edge.
    task automatic step(input string name, input logic res, unl, set, cnf, cnc, input logic [7:0] din,
                        input logic [5:0] pw, input logic [1:0] ph, err, input logic dn, fl, iv);
        Res = res; Unlocked = unl; Set = set; Confirm = cnf; Cancel = cnc; in_8 = din;
        @(posedge Clk);
        #1;
        total++;
        if (pw_6 !== pw || phase !== ph || err_cnt !== err || done !== dn || fail !== fl || invalid !== iv) begin
            bad++;
            $display("FAIL %s: got pw=%h ph=%b err=%0d done=%b fail=%b inv=%b, want pw=%h ph=%b err=%0d done=%b fail=%b inv=%b",
                     name, pw_6, phase, err_cnt, done, fail, invalid, pw, ph, err, dn, fl, iv);
        end
    endtask

    initial begin
        Res = 1'b1; Unlocked = 1'b0; Set = 1'b0; Confirm = 1'b0; Cancel = 1'b0; in_8 = 8'h00;
        @(negedge Clk);

        //   res unl set cnf cnc din      pw     ph     err  dn fl iv
        add(1, 0, 0, 0, 0, 8'h00, 6'h00, 2'b00, 2'd0, 0, 0, 0);   // reset state
        add(1, 1, 1, 0, 0, 8'h00, 6'h00, 2'b00, 2'd0, 0, 0, 0);   // Set held through reset
        add(0, 1, 1, 0, 0, 8'h00, 6'h00, 2'b00, 2'd0, 0, 0, 0);   // no edge after reset
        add(0, 1, 0, 0, 0, 8'h00, 6'h00, 2'b00, 2'd0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 8'h00, 6'h00, 2'b01, 2'd0, 0, 0, 0);   // session start
        add(0, 1, 0, 0, 0, 8'h2A, 6'h00, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h2A, 6'h00, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h2A, 6'h00, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h2A, 6'h2A, 2'b00, 2'd0, 1, 0, 0);   // commit
        add(0, 1, 0, 0, 0, 8'h2A, 6'h2A, 2'b00, 2'd0, 0, 0, 0);
        // three mismatches abort
        add(0, 1, 1, 0, 0, 8'h00, 6'h2A, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h15, 6'h2A, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h15, 6'h2A, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h16, 6'h2A, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h16, 6'h2A, 2'b01, 2'd1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h15, 6'h2A, 2'b01, 2'd1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h15, 6'h2A, 2'b10, 2'd1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h16, 6'h2A, 2'b10, 2'd1, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h16, 6'h2A, 2'b01, 2'd2, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h15, 6'h2A, 2'b01, 2'd2, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h15, 6'h2A, 2'b10, 2'd2, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h16, 6'h2A, 2'b10, 2'd2, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h16, 6'h2A, 2'b00, 2'd0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 8'h16, 6'h2A, 2'b00, 2'd0, 0, 0, 0);
        // invalid entries in both phases
        add(0, 1, 1, 0, 0, 8'h00, 6'h2A, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'hC5, 6'h2A, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'hC5, 6'h2A, 2'b01, 2'd0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 8'h11, 6'h2A, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h11, 6'h2A, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'hC5, 6'h2A, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'hC5, 6'h2A, 2'b10, 2'd0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 8'h11, 6'h2A, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h11, 6'h11, 2'b00, 2'd0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 8'h11, 6'h11, 2'b00, 2'd0, 0, 0, 0);
        // Unlocked drop with Cancel and Confirm edges in ENTER2
        add(0, 1, 1, 0, 0, 8'h00, 6'h11, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h3C, 6'h11, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h3C, 6'h11, 2'b10, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h3C, 6'h11, 2'b10, 2'd0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 8'h3C, 6'h11, 2'b00, 2'd0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 8'h3C, 6'h11, 2'b00, 2'd0, 0, 0, 0);
        // Cancel beats Confirm in ENTER1
        add(0, 1, 1, 0, 0, 8'h3C, 6'h11, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h3C, 6'h11, 2'b01, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 8'h3C, 6'h11, 2'b00, 2'd0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 8'h3C, 6'h11, 2'b00, 2'd0, 0, 0, 0);
        // Set while locked and Confirm in IDLE are ignored
        add(0, 0, 1, 0, 0, 8'h00, 6'h11, 2'b00, 2'd0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 6'h11, 2'b00, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 6'h11, 2'b00, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 8'h01, 6'h11, 2'b00, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 8'h01, 6'h11, 2'b00, 2'd0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].res, tbl[i].unl, tbl[i].set, tbl[i].cnf, tbl[i].cnc,
                 tbl[i].din, tbl[i].pw, tbl[i].ph, tbl[i].err, tbl[i].dn, tbl[i].fl, tbl[i].iv);
        end

        // Confirm held high: one transition only, then reset mid-ENTER2
        step("hold_set",  0, 1, 1, 0, 0, 8'h22, 6'h11, 2'b01, 2'd0, 0, 0, 0);
        step("hold_rel",  0, 1, 0, 0, 0, 8'h22, 6'h11, 2'b01, 2'd0, 0, 0, 0);
        for (int i = 0; i < HOLD; i++) begin
            step($sformatf("hold_cnf%0d", i), 0, 1, 0, 1, 0, 8'h22, 6'h11, 2'b10, 2'd0, 0, 0, 0);
        end
        step("mid_reset",  1, 1, 0, 1, 0, 8'h22, 6'h00, 2'b00, 2'd0, 0, 0, 0);
        step("post_reset", 0, 1, 0, 0, 0, 8'h22, 6'h00, 2'b00, 2'd0, 0, 0, 0);

        // Inactivity: abort on the 8th idle cycle only when the timeout is built in
        step("tmo_start", 0, 1, 1, 0, 0, 8'h00, 6'h00, 2'b01, 2'd0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            if (TMO_ON && i == 8)
                step("tmo_idle8", 0, 1, 0, 0, 0, 8'h00, 6'h00, 2'b00, 2'd0, 0, 1, 0);
            else
                step($sformatf("tmo_idle%0d", i), 0, 1, 0, 0, 0, 8'h00, 6'h00, 2'b01, 2'd0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
